// File: rtl/heptagon_flow_ctrl.sv
// Job sequencer for the heptagon-area sorting pipeline: loads vertices, runs the
// area datapath, launches the sorter, then streams ranked result indices out.
module heptagon_flow_ctrl #(
  parameter int N_POLY  = 5,
  parameter int N_VERT  = 7,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_x,
  input  logic [9:0] in_y,
  output logic       vert_we,
  output logic [5:0] vert_addr,
  output logic [9:0] vert_x,
  output logic [9:0] vert_y,
  output logic       calc_rst,
  output logic       cal_on,
  output logic       valid_on,
  input  logic       area_on,
  output logic       sort_start,
  input  logic       sort_done,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_idx,
  output logic       out_last,
  output logic       busy,
  output logic       err
);

  localparam int              WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [5:0]      LAST_ADDR = 6'(N_POLY * N_VERT - 1);
  localparam logic [2:0]      LAST_IDX  = 3'(N_POLY - 1);
  localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE    = WD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC_RST, S_CALC, S_SORT, S_OUT, S_ERR
  } state_t;

  // Handshakes: a word moves on in_valid & in_ready and a result on
  // out_valid & out_ready, both at the rising clk edge; valid never waits on ready.
  state_t          state;
  logic [5:0]      vert_cnt;
  logic [WD_W-1:0] wd;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      vert_cnt   <= '0;
      wd         <= '0;
      in_ready   <= 1'b0;
      vert_we    <= 1'b0;
      vert_addr  <= '0;
      vert_x     <= '0;
      vert_y     <= '0;
      calc_rst   <= 1'b0;
      cal_on     <= 1'b0;
      valid_on   <= 1'b0;
      sort_start <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Single-cycle strobes fall back to 0 unless a state raises them.
      vert_we    <= 1'b0;
      calc_rst   <= 1'b0;
      valid_on   <= 1'b0;
      sort_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            vert_cnt <= '0;
            in_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready) begin
            vert_we   <= 1'b1;
            vert_addr <= vert_cnt;
            vert_x    <= in_x;
            vert_y    <= in_y;
            vert_cnt  <= vert_cnt + 6'd1;
            if (vert_cnt == LAST_ADDR) begin
              in_ready <= 1'b0;
              calc_rst <= 1'b1;
              valid_on <= 1'b1;
              state    <= S_CALC_RST;
            end
          end
        end
        S_CALC_RST: begin
          wd     <= '0;
          cal_on <= 1'b1;
          state  <= S_CALC;
        end
        S_CALC: begin
          // A done indication beats the watchdog when both land together.
          if (area_on) begin
            cal_on     <= 1'b0;
            sort_start <= 1'b1;
            wd         <= '0;
            state      <= S_SORT;
          end else if (wd == WD_MAX) begin
            cal_on <= 1'b0;
            err    <= 1'b1;
            state  <= S_ERR;
          end else begin
            wd <= wd + WD_ONE;
          end
        end
        S_SORT: begin
          if (sort_done) begin
            out_idx   <= '0;
            out_valid <= 1'b1;
            out_last  <= (LAST_IDX == 3'd0);
            state     <= S_OUT;
          end else if (wd == WD_MAX) begin
            err   <= 1'b1;
            state <= S_ERR;
          end else begin
            wd <= wd + WD_ONE;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              valid_on  <= 1'b1;
              state     <= S_IDLE;
            end else begin
              out_idx  <= out_idx + 3'd1;
              out_last <= ((out_idx + 3'd1) == LAST_IDX);
            end
          end
        end
        S_ERR: begin
          err       <= 1'b1;
          in_ready  <= 1'b0;
          cal_on    <= 1'b0;
          out_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heptagon_flow_ctrl.sv
// Directed bench for heptagon_flow_ctrl: load, calc, sort, output, watchdog
// and reset scenarios, each checked against hand-derived cycle expectations.
module tb_heptagon_flow_ctrl;

  localparam int N_POLY  = 5;
  localparam int N_VERT  = 7;
  localparam int TIMEOUT = 255;
  localparam int N_WORDS = N_POLY * N_VERT;

  logic       clk, reset, start, in_valid, in_ready;
  logic [9:0] in_x, in_y;
  logic       vert_we;
  logic [5:0] vert_addr;
  logic [9:0] vert_x, vert_y;
  logic       calc_rst, cal_on, valid_on, area_on, sort_start, sort_done;
  logic       out_valid, out_ready, out_last, busy, err;
  logic [2:0] out_idx;
  logic [38:0] all_out;

  int checks   = 0;
  int failures = 0;

  assign all_out = {in_ready, vert_we, vert_addr, vert_x, vert_y, calc_rst, cal_on,
                    valid_on, sort_start, out_valid, out_idx, out_last, busy, err};

  heptagon_flow_ctrl #(.N_POLY(N_POLY), .N_VERT(N_VERT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .vert_we(vert_we), .vert_addr(vert_addr),
    .vert_x(vert_x), .vert_y(vert_y), .calc_rst(calc_rst), .cal_on(cal_on),
    .valid_on(valid_on), .area_on(area_on), .sort_start(sort_start),
    .sort_done(sort_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .err(err)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
    area_on = 1'b0; sort_done = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL idle_without_start got busy=%b in_ready=%b exp 0 0", busy, in_ready);
    end
  endtask

  // Starts a job from IDLE and pushes N_WORDS vertices (x=addr, y=2*addr).
  // Leaves the DUT at the negedge of its first CALC cycle.
  task automatic load_job(input bit gaps, input bit restart);
    int sent = 0;
    int writes = 0;
    int cyc = 0;
    bit hs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL start_accept got in_ready=%b busy=%b exp 1 1", in_ready, busy);
    end
    while (sent < N_WORDS && cyc < 300) begin
      in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      in_x     = 10'(sent);
      in_y     = 10'(2 * sent);
      start    = (restart && sent == 17);
      hs       = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (hs) sent++;
      if (vert_we === 1'b1) begin
        checks++;
        if (vert_addr !== 6'(writes) || vert_x !== 10'(writes) || vert_y !== 10'(2 * writes)) begin
          failures++;
          $display("FAIL vert_write got addr=%0d x=%0d y=%0d exp addr=%0d x=%0d y=%0d",
                   vert_addr, vert_x, vert_y, writes, writes, 2 * writes);
        end
        writes++;
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("FAIL load_busy got=%b exp=1", busy);
      end
      if (sent < N_WORDS) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++; $display("FAIL load_in_ready got=%b exp=1 (sent=%0d)", in_ready, sent);
        end
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    checks++;
    if (sent != N_WORDS) begin
      failures++; $display("FAIL load_budget got sent=%0d exp=%0d", sent, N_WORDS);
    end
    checks++;
    if ({in_ready, calc_rst, valid_on, cal_on} !== 4'b0110) begin
      failures++;
      $display("FAIL calc_rst_cycle got in_ready=%b calc_rst=%b valid_on=%b cal_on=%b exp 0 1 1 0",
               in_ready, calc_rst, valid_on, cal_on);
    end
    @(negedge clk);
    checks++;
    if ({calc_rst, valid_on, cal_on, vert_we} !== 4'b0010) begin
      failures++;
      $display("FAIL calc_entry got calc_rst=%b valid_on=%b cal_on=%b vert_we=%b exp 0 0 1 0",
               calc_rst, valid_on, cal_on, vert_we);
    end
    checks++;
    if (writes != N_WORDS) begin
      failures++; $display("FAIL write_count got=%0d exp=%0d", writes, N_WORDS);
    end
  endtask

  // From the first CALC cycle: area_on on CALC cycle calc_cycles, sort_done on
  // SORT cycle sort_cycles. Leaves the DUT at the first OUT negedge.
  task automatic test_calc_sort(input int calc_cycles, input int sort_cycles);
    repeat (calc_cycles - 1) @(negedge clk);
    checks++;
    if (cal_on !== 1'b1 || sort_start !== 1'b0) begin
      failures++; $display("FAIL calc_hold got cal_on=%b sort_start=%b exp 1 0", cal_on, sort_start);
    end
    area_on = 1'b1;
    @(negedge clk);
    area_on = 1'b0;
    checks++;
    if (cal_on !== 1'b0 || sort_start !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL sort_launch got cal_on=%b sort_start=%b err=%b exp 0 1 0", cal_on, sort_start, err);
    end
    repeat (sort_cycles - 1) @(negedge clk);
    checks++;
    if (sort_start !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sort_wait got sort_start=%b out_valid=%b exp 0 0", sort_start, out_valid);
    end
    sort_done = 1'b1;
    @(negedge clk);
    sort_done = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL out_entry got valid=%b idx=%0d last=%b exp 1 0 0", out_valid, out_idx, out_last);
    end
  endtask

  task automatic test_out();
    int pat [7];
    int exp_idx [7];
    pat     = '{1, 0, 0, 1, 1, 1, 1};
    exp_idx = '{0, 1, 1, 1, 2, 3, 4};
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'(exp_idx[k]) || out_last !== (exp_idx[k] == 4)) begin
        failures++;
        $display("FAIL out_step%0d got valid=%b idx=%0d last=%b exp 1 %0d %b",
                 k, out_valid, out_idx, out_last, exp_idx[k], exp_idx[k] == 4);
      end
      out_ready = pat[k][0];
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if ({out_valid, out_last, valid_on, busy} !== 4'b0010) begin
      failures++;
      $display("FAIL out_exit got valid=%b last=%b valid_on=%b busy=%b exp 0 0 1 0",
               out_valid, out_last, valid_on, busy);
    end
    @(negedge clk);
    checks++;
    if (valid_on !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL valid_on_single got valid_on=%b busy=%b exp 0 0", valid_on, busy);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int cyc = 0;
    while (err !== 1'b1 && cyc < 400) begin
      if (cal_on === 1'b1) n++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL timeout_err got=%b exp=1", err);
    end
    // Watchdog counts 0..TIMEOUT inside CALC before tripping.
    checks++;
    if (n < TIMEOUT || n > TIMEOUT + 1) begin
      failures++; $display("FAIL timeout_length got=%0d exp=%0d..%0d", n, TIMEOUT, TIMEOUT + 1);
    end
    checks++;
    if ({cal_on, in_ready, out_valid, busy} !== 4'b0001) begin
      failures++;
      $display("FAIL err_outputs got cal_on=%b in_ready=%b out_valid=%b busy=%b exp 0 0 0 1",
               cal_on, in_ready, out_valid, busy);
    end
    start = 1'b1;
    area_on = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    area_on = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b1 || sort_start !== 1'b0) begin
      failures++;
      $display("FAIL err_sticky got err=%b busy=%b sort_start=%b exp 1 1 0", err, busy, sort_start);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL err_reset got=%h exp=0", all_out);
    end
  endtask

  task automatic test_reset_mid_out();
    load_job(1'b0, 1'b0);
    test_calc_sort(5, 3);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_idx !== 3'd2) begin
      failures++; $display("FAIL mid_out_idx got=%0d exp=2", out_idx);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({out_valid, out_idx, busy, err} !== 6'b0) begin
      failures++;
      $display("FAIL mid_out_reset got valid=%b idx=%0d busy=%b err=%b exp 0 0 0 0",
               out_valid, out_idx, busy, err);
    end
  endtask

  initial begin
    test_reset();
    load_job(1'b0, 1'b0);
    test_calc_sort(120, 10);
    test_out();
    load_job(1'b1, 1'b1);
    test_timeout();
    test_reset_mid_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/heptagon_flow_ctrl.md
Name: heptagon_flow_ctrl

Overview:
- Top-level sequencer for the heptagon-area sorting pipeline.
- Accepts a job of N_POLY×N_VERT vertex pairs over a valid/ready stream and writes them into the vertex buffer.
- Runs the area-calculation datapath through its cal_on/area_on/valid_on protocol, then launches the sorter.
- Streams sorted result indices to the consumer, with a watchdog guarding both wait phases.

Parameters:
- N_POLY, 5, polygons per job.
- N_VERT, 7, vertices per polygon.
- TIMEOUT, 255, maximum cycles allowed in CALC or in SORT before error.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  job start request, sampled only in IDLE.
- in_valid  in  1  vertex word valid.
- in_ready  out  1  vertex word accepted when in_valid&in_ready.
- in_x  in  10  vertex x.
- in_y  in  10  vertex y.
- vert_we  out  1  vertex buffer write enable.
- vert_addr  out  6  buffer address, 0..N_POLY*N_VERT-1.
- vert_x  out  10  write data x.
- vert_y  out  10  write data y.
- calc_rst  out  1  one-cycle reset pulse to the area datapath (active-high on that side).
- cal_on  out  1  area datapath run level.
- valid_on  out  1  one-cycle pulse clearing datapath area_on.
- area_on  in  1  area datapath done level.
- sort_start  out  1  one-cycle sorter launch pulse.
- sort_done  in  1  sorter done.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_idx  out  3  rank position 0..N_POLY-1 for reading sorted results.
- out_last  out  1  high with the final out_idx.
- busy  out  1  state != IDLE.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state = IDLE; every output 0; vertex counter, watchdog and out counter all 0.
  - Reset overrides any state, including a reset mid-job.
- Outputs: all outputs are registered except busy, which is decoded from state.
- IDLE:
  - in_ready = 0.
  - start==1 → LOAD, vertex counter = 0.
  - start is ignored in every other state.
- LOAD:
  - in_ready = 1.
  - Each handshake registers vert_we=1, vert_addr=count, vert_x=in_x, vert_y=in_y, so the write appears one cycle after the handshake.
  - Then count++.
  - in_valid with in_ready low is ignored with no write; gaps in in_valid are allowed.
  - On the handshake with count == N_POLY*N_VERT-1, in_ready drops the next cycle and the state goes to CALC_RST.
- CALC_RST (1 cycle):
  - calc_rst = 1, valid_on = 1 for this cycle.
  - Watchdog cleared.
  - → CALC. The final buffer write lands in this cycle.
- CALC:
  - cal_on = 1 and held continuously; watchdog++ each cycle.
  - area_on==1 → cal_on = 0 next cycle, sort_start pulses 1 cycle, watchdog cleared, → SORT.
  - Watchdog == TIMEOUT with area_on still 0 → ERR.
- SORT:
  - Watchdog++ each cycle.
  - sort_done==1 → OUT, out_idx = 0.
  - Watchdog == TIMEOUT → ERR.
- OUT:
  - out_valid = 1; out_last = (out_idx == N_POLY-1).
  - out_idx is held stable while out_ready==0.
  - Each handshake increments out_idx.
  - On the handshake with out_last=1: out_valid = 0, valid_on pulses 1 cycle, → IDLE.
  - If start is high in that same cycle, it is not taken; it is sampled from the next cycle in IDLE.
- ERR:
  - err = 1; in_ready = cal_on = out_valid = 0.
  - Remains in ERR until reset.
- Simultaneous events:
  - area_on and the watchdog terminal count in the same cycle: area_on wins.
  - The same rule applies to sort_done versus terminal count in SORT.

Test Plan:
- Start pulse, then 35 back-to-back vertices with in_x=addr and in_y=2*addr → vert_we pulses 35 times with addr 0..34 and matching data; in_ready low from the cycle after the 35th handshake; single calc_rst/valid_on cycle; cal_on rises the following cycle.
- Same load with in_valid toggling every other cycle and start re-pulsed mid-load → exactly 35 writes; start ignored; busy stays 1.
- Model area_on asserting 120 cycles into CALC → cal_on falls and sort_start pulses the next cycle; sort_done after 10 cycles → out_valid with out_idx=0.
- out_ready pattern 1,0,0,1,1,1,1 → out_idx sequence 0,1,1,1,2,3,4; out_last only at 4; after the last handshake, valid_on pulses once, busy=0, and a new start is accepted.
- area_on held low for 255 cycles in CALC → err=1, cal_on=0, in_ready=0; remains in ERR until reset=0 for one edge, after which all outputs are 0.
- Drive reset low mid-OUT at out_idx=2 → next cycle out_valid=0, out_idx=0, busy=0, err=0.
